// File: rtl/serializer_pkg.sv
// Shared types and sizing for the serializer (parallel word -> MSB-first serial stream).
package serializer_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned MOD_W   = $clog2(DATA_W);
   localparam int unsigned MIN_LEN = 3;

   typedef enum logic {IDLE, SEND} state_t;

endpackage

// File: rtl/serializer_hold_buf.sv
// One-entry hold buffer (word and length-1) used only when SERIALIZER_QUEUE_EN is defined.
module serializer_hold_buf
   import serializer_pkg::*;
(
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic [MOD_W-1:0]  push_len_m1,
   input  logic              pop,
   output logic              full,
   output logic [DATA_W-1:0] data,
   output logic [MOD_W-1:0]  len_m1
);

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         full   <= 1'b0;
         data   <= '0;
         len_m1 <= '0;
      end else if (push) begin
         full   <= 1'b1;
         data   <= push_data;
         len_m1 <= push_len_m1;
      end else if (pop) begin
         full   <= 1'b0;
      end
   end

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB first, per-transfer length via data_mod_i.
// Define SERIALIZER_QUEUE_EN to add a one-entry hold buffer for gap-free back-to-back words.
module serializer
   import serializer_pkg::*;
(
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [MOD_W-1:0]  data_mod_i,
   input  logic              data_val_i,
   output logic              ser_data_o,
   output logic              ser_data_val_o,
   output logic              busy_o
);

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [MOD_W-1:0]  cnt;
   logic              in_legal;
   logic              accept;
   logic [MOD_W-1:0]  in_len_m1;

   logic              buf_push;
   logic              buf_pop;
   logic              buf_full;
   logic [DATA_W-1:0] buf_data;
   logic [MOD_W-1:0]  buf_len_m1;

   assign in_legal  = (data_mod_i == '0) || (data_mod_i >= MOD_W'(MIN_LEN));
   assign accept    = data_val_i && in_legal;
   assign in_len_m1 = (data_mod_i == '0) ? MOD_W'(DATA_W - 1) : data_mod_i - MOD_W'(1);

`ifdef SERIALIZER_QUEUE_EN
   localparam bit QUEUE_EN = 1'b1;

   // Capture is refused on the last-bit edge so an empty buffer there behaves as unbuffered.
   assign buf_push = (state == SEND) && !buf_full && (cnt != '0) && accept;
   assign buf_pop  = (state == SEND) && (cnt == '0) && buf_full;

   serializer_hold_buf u_hold_buf (
      .clk_i       (clk_i),
      .arst_i      (arst_i),
      .push        (buf_push),
      .push_data   (data_i),
      .push_len_m1 (in_len_m1),
      .pop         (buf_pop),
      .full        (buf_full),
      .data        (buf_data),
      .len_m1      (buf_len_m1)
   );
`else
   localparam bit QUEUE_EN = 1'b0;

   assign buf_push   = 1'b0;
   assign buf_pop    = 1'b0;
   assign buf_full   = 1'b0;
   assign buf_data   = '0;
   assign buf_len_m1 = '0;
`endif

   // cnt holds the number of bits still to follow the one currently on ser_data_o.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state          <= IDLE;
         shreg          <= '0;
         cnt            <= '0;
         ser_data_o     <= 1'b0;
         ser_data_val_o <= 1'b0;
         busy_o         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state          <= SEND;
                  shreg          <= data_i << 1;
                  cnt            <= in_len_m1;
                  ser_data_o     <= data_i[DATA_W-1];
                  ser_data_val_o <= 1'b1;
                  busy_o         <= !QUEUE_EN;
               end
            end
            SEND: begin
               if (cnt != '0) begin
                  shreg          <= shreg << 1;
                  cnt            <= cnt - MOD_W'(1);
                  ser_data_o     <= shreg[DATA_W-1];
                  ser_data_val_o <= 1'b1;
                  busy_o         <= QUEUE_EN ? (buf_full || buf_push) : 1'b1;
               end else if (buf_pop) begin
                  shreg          <= buf_data << 1;
                  cnt            <= buf_len_m1;
                  ser_data_o     <= buf_data[DATA_W-1];
                  ser_data_val_o <= 1'b1;
                  busy_o         <= 1'b0;
               end else begin
                  state          <= IDLE;
                  ser_data_o     <= 1'b0;
                  ser_data_val_o <= 1'b0;
                  busy_o         <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: bit/word scoreboard plus busy/valid timing checks.
module tb_serializer;
   import serializer_pkg::*;

`ifdef SERIALIZER_QUEUE_EN
   localparam bit QMODE = 1'b1;
`else
   localparam bit QMODE = 1'b0;
`endif

   typedef struct {
      logic [DATA_W-1:0] data;
      int unsigned       len;
   } word_t;

   logic              clk_i = 1'b0;
   logic              arst_i = 1'b0;
   logic [DATA_W-1:0] data_i = '0;
   logic [MOD_W-1:0]  data_mod_i = '0;
   logic              data_val_i = 1'b0;
   logic              ser_data_o;
   logic              ser_data_val_o;
   logic              busy_o;

   logic              exp_bits[$];
   word_t             exp_words[$];
   logic [DATA_W-1:0] acc = '0;
   int unsigned       acc_n = 0;
   int unsigned       words_done = 0;
   int                n_pass = 0;
   int                n_total = 0;

   serializer dut (
      .clk_i          (clk_i),
      .arst_i         (arst_i),
      .data_i         (data_i),
      .data_mod_i     (data_mod_i),
      .data_val_i     (data_val_i),
      .ser_data_o     (ser_data_o),
      .ser_data_val_o (ser_data_val_o),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and run the serial-side scoreboard (acts as the deserializer model).
   task automatic tick();
      logic  b;
      word_t w;
      @(negedge clk_i);
      if (!arst_i) begin
         if (!ser_data_val_o) begin
            check("ser_zero_when_invalid", {31'd0, ser_data_o}, 32'd0);
         end else if (exp_bits.size() == 0) begin
            check("unexpected_bit", {31'd0, ser_data_val_o}, 32'd0);
         end else begin
            b = exp_bits.pop_front();
            check("bit", {31'd0, ser_data_o}, {31'd0, b});
            acc = {acc[DATA_W-2:0], ser_data_o};
            acc_n++;
            if (exp_words.size() > 0 && acc_n == exp_words[0].len) begin
               w = exp_words.pop_front();
               check("word", {16'd0, acc}, {16'd0, w.data >> (DATA_W - w.len)});
               acc = '0;
               acc_n = 0;
               words_done++;
            end
         end
      end
   endtask

   // Present a word for one edge; returns at the falling edge inside cycle N+1.
   task automatic send(input logic [DATA_W-1:0] d, input logic [MOD_W-1:0] m, input bit expect_accept);
      word_t       w;
      int unsigned len;
      len = (m == '0) ? DATA_W : int'(m);
      if (expect_accept) begin
         for (int unsigned i = 0; i < len; i++) exp_bits.push_back(d[DATA_W-1-i]);
         w.data = d;
         w.len  = len;
         exp_words.push_back(w);
      end
      data_i     = d;
      data_mod_i = m;
      data_val_i = 1'b1;
      tick();
      data_val_i = 1'b0;
      data_i     = ~d;
      data_mod_i = MOD_W'(5);
   endtask

   task automatic wait_not_busy(input int limit);
      int k = 0;
      while (busy_o && k < limit) begin
         tick();
         k++;
      end
      check("busy_release", {31'd0, busy_o}, 32'd0);
   endtask

   task automatic wait_idle(input int limit);
      int k = 0;
      while ((ser_data_val_o || busy_o || exp_bits.size() != 0) && k < limit) begin
         tick();
         k++;
      end
      check("drain_val", {31'd0, ser_data_val_o}, 32'd0);
      check("drain_pending", exp_bits.size(), 32'd0);
   endtask

   initial begin
      int unsigned wd;
      logic [DATA_W-1:0] loop_words[4];
      loop_words = '{16'h1234, 16'hFFFF, 16'h0000, 16'hBEEF};

      // Reset, asserted before any clock edge
      #1 arst_i = 1'b1;
      #1;
      check("rst_ser", {31'd0, ser_data_o}, 32'd0);
      check("rst_val", {31'd0, ser_data_val_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      tick();
      tick();
      arst_i = 1'b0;
      tick();

      // Full word, mod 0
      send(16'hA5C3, '0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         check("busy_full_word", {31'd0, busy_o}, {31'd0, !QMODE});
         check("val_full_word", {31'd0, ser_data_val_o}, 32'd1);
         tick();
      end
      check("full_end_val", {31'd0, ser_data_val_o}, 32'd0);
      check("full_end_busy", {31'd0, busy_o}, 32'd0);

      // Minimum length word
      send(16'hE000, MOD_W'(3), 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("busy_short", {31'd0, busy_o}, {31'd0, !QMODE});
         tick();
      end
      check("short_end_val", {31'd0, ser_data_val_o}, 32'd0);
      check("short_end_busy", {31'd0, busy_o}, 32'd0);
      tick();

      // Illegal lengths 1 and 2 are dropped
      for (int m = 1; m <= 2; m++) begin
         send(16'hFFFF, MOD_W'(m), 1'b0);
         for (int i = 0; i < 20; i++) begin
            check("illegal_val", {31'd0, ser_data_val_o}, 32'd0);
            check("illegal_busy", {31'd0, busy_o}, 32'd0);
            tick();
         end
      end

      // Second word offered while the first is in flight
      send(16'hC3A5, '0, 1'b1);
      repeat (4) tick();
      if (QMODE) begin
         for (int i = 0; i < 8; i++) exp_bits.push_back(1'b0);
         exp_words.push_back('{data: 16'h00FF, len: 8});
      end
      data_i     = 16'h00FF;
      data_mod_i = MOD_W'(8);
      data_val_i = 1'b1;
      tick();
      data_val_i = 1'b0;
      data_i     = 16'hFFFF;
      check("busy_after_offer", {31'd0, busy_o}, 32'd1);
      repeat (10) tick();
      check("last_bit_val", {31'd0, ser_data_val_o}, 32'd1);
      tick();
      check("gap_after_word", {31'd0, ser_data_val_o}, {31'd0, QMODE});
      check("busy_after_last", {31'd0, busy_o}, 32'd0);
      wait_idle(40);
      tick();

      // Asynchronous reset mid-word
      send(16'h5A5A, '0, 1'b1);
      repeat (4) tick();
      #2 arst_i = 1'b1;
      #1;
      check("arst_ser", {31'd0, ser_data_o}, 32'd0);
      check("arst_val", {31'd0, ser_data_val_o}, 32'd0);
      check("arst_busy", {31'd0, busy_o}, 32'd0);
      exp_bits.delete();
      exp_words.delete();
      acc   = '0;
      acc_n = 0;
      tick();
      arst_i = 1'b0;
      tick();
      send(16'h8001, '0, 1'b1);
      wait_idle(40);
      check("post_reset_word_done", exp_words.size(), 32'd0);

      // Loopback: four full words reassembled by the bench-side deserializer model
      wd = words_done;
      for (int i = 0; i < 4; i++) begin
         send(loop_words[i], '0, 1'b1);
         wait_not_busy(100);
      end
      wait_idle(100);
      check("loop_word_count", words_done - wd, 32'd4);
      check("loop_words_left", exp_words.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
